key_direction_ctrl: RTL and testbench

Input-conditioning stage directly upstream of `gameController`. Synchronises and debounces the five raw push-buttons (`keyUp`, `KeyDown`, `keyLeft`, `keyRight`, `keyRestart`), generates one-cycle press pulses, and holds the player's movement direction with a one-entry pending-request buffer that `gameController` consumes on each game step (`tick`). Reversal requests (e.g. LEFT while moving RIGHT) are rejected here, so the game logic only sees legal directions.

---
 rtl/game_pkg.sv | 37 +++
 rtl/key_debounce.sv | 55 +++++
 rtl/key_direction_ctrl.sv | 88 ++++++++
 tb/tb_key_direction_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Direction encoding and helpers shared between the key conditioning stage
// and gameController.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } dir_req_t;

    localparam int NUM_KEYS = 5;

    // UP<->DOWN and LEFT<->RIGHT differ only in the low bit.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    // Fixed priority UP > DOWN > LEFT > RIGHT; lower-priority presses are dropped.
    function automatic dir_req_t pick_request(input logic [3:0] p);
        dir_req_t r;
        r.valid = 1'b1;
        r.dir   = DIR_RIGHT;
        if (p[0])      r.dir = DIR_UP;
        else if (p[1]) r.dir = DIR_DOWN;
        else if (p[2]) r.dir = DIR_LEFT;
        else if (p[3]) r.dir = DIR_RIGHT;
        else           r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, polarity normalisation, debounce
// counter and a registered one-cycle press pulse on the accepted 0->1 edge.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic            RELEASED = KEY_ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             synced;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    assign synced = sync_p1 ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0  <= RELEASED;
            sync_p1  <= RELEASED;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            // synchroniser stage
            sync_p0  <= raw;
            sync_p1  <= sync_p0;
            // debounce stage: any return to the stable level restarts the count
            if (synced != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= synced;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            // edge stage
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/key_direction_ctrl.sv
// Conditions the five game buttons and keeps the committed movement direction
// plus a one-entry pending request consumed on each game tick.
module key_direction_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       keyUp,
    input  logic       KeyDown,
    input  logic       keyLeft,
    input  logic       keyRight,
    input  logic       keyRestart,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic [3:0] press,
    output logic       restart_pulse
);

    logic [NUM_KEYS-1:0] raw_keys;
    logic [NUM_KEYS-1:0] pulses;

    assign raw_keys = {keyRestart, keyRight, keyLeft, KeyDown, keyUp};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_key (
            .clk  (CLOCK_50),
            .rst  (reset),
            .raw  (raw_keys[i]),
            .pulse(pulses[i])
        );
    end

    assign press         = pulses[3:0];
    assign restart_pulse = pulses[NUM_KEYS-1];

    dir_t     dir_q;
    dir_t     pend_dir;
    logic     pend_valid;
    logic     commit;
    dir_t     ref_dir;
    dir_req_t req;
    logic     accept;

    assign dir = dir_q;

    // Legality is judged against the direction that will hold after this cycle's commit.
    always_comb begin
        req     = pick_request(press);
        commit  = tick & pend_valid;
        ref_dir = commit ? pend_dir : dir_q;
        accept  = req.valid && (req.dir != ref_dir) && (req.dir != opposite(ref_dir));
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dir_q       <= DIR_RIGHT;
            dir_changed <= 1'b0;
            pend_valid  <= 1'b0;
            pend_dir    <= DIR_RIGHT;
        end else begin
            dir_changed <= 1'b0;
            if (restart_pulse) begin
                dir_q       <= DIR_RIGHT;
                pend_valid  <= 1'b0;
                dir_changed <= (dir_q != DIR_RIGHT);
            end else begin
                if (commit) begin
                    dir_q       <= pend_dir;
                    dir_changed <= (pend_dir != dir_q);
                end
                if (accept) begin
                    pend_valid <= 1'b1;
                    pend_dir   <= req.dir;
                end else if (tick) begin
                    pend_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_direction_ctrl.sv
// Directed bench for key_direction_ctrl with a 4-cycle debounce interval.
module tb_key_direction_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] keys_n;   // {restart, right, left, down, up}, active low
    logic       tick;
    logic [1:0] dir;
    logic       dir_changed;
    logic [3:0] press;
    logic       restart_pulse;

    int n_cmp = 0;
    int n_err = 0;

    key_direction_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .keyUp        (keys_n[0]),
        .KeyDown      (keys_n[1]),
        .keyLeft      (keys_n[2]),
        .keyRight     (keys_n[3]),
        .keyRestart   (keys_n[4]),
        .tick         (tick),
        .dir          (dir),
        .dir_changed  (dir_changed),
        .press        (press),
        .restart_pulse(restart_pulse)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Holds the masked keys 7 edges (pulse expected after the 7th), then
    // releases and lets the release settle; reports the pulse and strays.
    task automatic press_key(input logic [4:0] mask, output logic [3:0] pv,
                             output logic rp, output int stray);
        stray = 0;
        pv    = '0;
        rp    = 1'b0;
        keys_n = keys_n & ~mask;
        for (int j = 0; j < 7; j++) begin
            step();
            if (j == 6) begin
                pv = press;
                rp = restart_pulse;
            end else if (press != 4'b0 || restart_pulse) begin
                stray++;
            end
        end
        keys_n = keys_n | mask;
        for (int j = 0; j < 8; j++) begin
            step();
            if (press != 4'b0 || restart_pulse) stray++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if ({dir, press, restart_pulse, dir_changed} !== {2'b11, 4'b0000, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: dir=%b press=%b rp=%b dc=%b, required dir=11 press=0000 rp=0 dc=0",
                         i, dir, press, restart_pulse, dir_changed);
            end
        end
    endtask

    task automatic test_up_press();
        int first = -1;
        int cnt = 0;
        logic [3:0] first_val = '0;
        keys_n[0] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (press != 4'b0) begin
                if (first < 0) begin
                    first = j;
                    first_val = press;
                end
                cnt++;
            end
        end
        n_cmp++;
        if (first !== 6) begin
            n_err++;
            $display("FAIL up_latency: pulse at edge k+%0d, required k+6", first);
        end
        n_cmp++;
        if (first_val !== 4'b0001) begin
            n_err++;
            $display("FAIL up_press_value: press=%b, required 0001", first_val);
        end
        n_cmp++;
        if (cnt !== 1) begin
            n_err++;
            $display("FAIL up_held_once: %0d pulses, required 1", cnt);
        end
        keys_n[0] = 1'b1;
        cnt = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (press != 4'b0) cnt++;
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_err++;
            $display("FAIL up_release_no_pulse: %0d pulses, required 0", cnt);
        end
        do_tick();
        n_cmp++;
        if ({dir, dir_changed} !== {2'b00, 1'b1}) begin
            n_err++;
            $display("FAIL up_commit: dir=%b dc=%b, required dir=00 dc=1", dir, dir_changed);
        end
        step();
        n_cmp++;
        if ({dir, dir_changed} !== {2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL up_dc_one_cycle: dir=%b dc=%b, required dir=00 dc=0", dir, dir_changed);
        end
    endtask

    task automatic test_bounce();
        int cnt = 0;
        for (int i = 0; i < 20; i++) begin
            keys_n[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            if (press != 4'b0) cnt++;
        end
        keys_n[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (press != 4'b0) cnt++;
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_err++;
            $display("FAIL bounce_no_pulse: %0d pulses, required 0", cnt);
        end
        n_cmp++;
        if (dir !== 2'b00) begin
            n_err++;
            $display("FAIL bounce_dir: dir=%b, required 00", dir);
        end
    endtask

    task automatic test_restart_with_tick();
        logic [3:0] pv;
        logic       rp;
        int         stray;
        int         early = 0;
        press_key(5'b00100, pv, rp, stray);
        n_cmp++;
        if ({pv, stray} !== {4'b0100, 32'sd0}) begin
            n_err++;
            $display("FAIL restart_left_press: press=%b stray=%0d, required 0100 stray=0", pv, stray);
        end
        keys_n[4] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (restart_pulse) early++;
        end
        step();
        n_cmp++;
        if ({restart_pulse, early} !== {1'b1, 32'sd0}) begin
            n_err++;
            $display("FAIL restart_pulse: rp=%b early=%0d, required rp=1 early=0", restart_pulse, early);
        end
        do_tick();
        n_cmp++;
        if ({dir, dir_changed, restart_pulse} !== {2'b11, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL restart_override: dir=%b dc=%b rp=%b, required dir=11 dc=1 rp=0",
                     dir, dir_changed, restart_pulse);
        end
        step();
        n_cmp++;
        if (dir_changed !== 1'b0) begin
            n_err++;
            $display("FAIL restart_dc_once: dc=%b, required 0", dir_changed);
        end
        keys_n[4] = 1'b1;
        for (int j = 0; j < 8; j++) step();
        do_tick();
        n_cmp++;
        if ({dir, dir_changed} !== {2'b11, 1'b0}) begin
            n_err++;
            $display("FAIL restart_pend_cleared: dir=%b dc=%b, required dir=11 dc=0", dir, dir_changed);
        end
    endtask

    task automatic test_reject();
        logic [3:0] pv;
        logic       rp;
        int         stray;
        press_key(5'b00100, pv, rp, stray);
        n_cmp++;
        if ({pv, stray} !== {4'b0100, 32'sd0}) begin
            n_err++;
            $display("FAIL reject_left_press: press=%b stray=%0d, required 0100 stray=0", pv, stray);
        end
        do_tick();
        n_cmp++;
        if ({dir, dir_changed} !== {2'b11, 1'b0}) begin
            n_err++;
            $display("FAIL reject_reversal: dir=%b dc=%b, required dir=11 dc=0", dir, dir_changed);
        end
        press_key(5'b00010, pv, rp, stray);
        n_cmp++;
        if ({pv, stray} !== {4'b0010, 32'sd0}) begin
            n_err++;
            $display("FAIL reject_down_press: press=%b stray=%0d, required 0010 stray=0", pv, stray);
        end
        press_key(5'b00100, pv, rp, stray);
        do_tick();
        n_cmp++;
        if ({dir, dir_changed} !== {2'b01, 1'b1}) begin
            n_err++;
            $display("FAIL reject_keeps_down: dir=%b dc=%b, required dir=01 dc=1", dir, dir_changed);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] pv;
        logic       rp;
        int         stray;
        press_key(5'b10000, pv, rp, stray);
        n_cmp++;
        if ({rp, dir, stray} !== {1'b1, 2'b11, 32'sd0}) begin
            n_err++;
            $display("FAIL simul_restart: rp=%b dir=%b stray=%0d, required rp=1 dir=11 stray=0", rp, dir, stray);
        end
        press_key(5'b00101, pv, rp, stray);
        n_cmp++;
        if (pv !== 4'b0101) begin
            n_err++;
            $display("FAIL simul_press: press=%b, required 0101", pv);
        end
        do_tick();
        n_cmp++;
        if ({dir, dir_changed} !== {2'b00, 1'b1}) begin
            n_err++;
            $display("FAIL simul_priority: dir=%b dc=%b, required dir=00 dc=1", dir, dir_changed);
        end
        // Empty buffer: tick must leave everything alone.
        step();
        do_tick();
        n_cmp++;
        if ({dir, dir_changed} !== {2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL empty_tick: dir=%b dc=%b, required dir=00 dc=0", dir, dir_changed);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int first = -1;
        int cnt = 0;
        keys_n[0] = 1'b0;
        for (int j = 0; j < 3; j++) step();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({dir, press, dir_changed} !== {2'b11, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: dir=%b press=%b dc=%b, required dir=11 press=0000 dc=0",
                     dir, press, dir_changed);
        end
        step();
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (press != 4'b0) begin
                if (first < 0) first = j;
                cnt++;
            end
        end
        n_cmp++;
        if ({first, cnt} !== {32'sd6, 32'sd1}) begin
            n_err++;
            $display("FAIL reset_full_interval: first pulse k+%0d count %0d, required k+6 count 1", first, cnt);
        end
        keys_n[0] = 1'b1;
        for (int j = 0; j < 8; j++) step();
    endtask

    initial begin
        reset  = 1'b1;
        keys_n = 5'b11111;
        tick   = 1'b0;
        @(negedge clk);
        test_reset();
        test_up_press();
        test_bounce();
        test_restart_with_tick();
        test_reject();
        test_simultaneous();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
